wb_mem_slave: RTL

- Pipelined Wishbone B4 responder: on-chip word-addressed memory at the far end of the L1 memory-access unit's bus.
- Serves single-beat writes and cache-line read bursts issued back-to-back with stb held high.
- Returns one ack, or one err, per accepted beat, in order, after a fixed latency.
- Provides a deterministic stall pattern so the master's back-pressure path is exercised in system simulation.

---
 rtl/wb_mem_slave.sv | 118 +++++++++++
 1 files changed

// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone B4 memory responder with fixed response latency
// and an optional deterministic stall pattern for back-pressure testing.
module wb_mem_slave #(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned AWIDTH      = 32,
    parameter int unsigned MEM_AW      = 10,
    parameter logic [AWIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned STALL_EVERY = 0
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [AWIDTH-1:0]   wb_adr_i,
    input  logic [DWIDTH-1:0]   wb_dat_i,
    input  logic [DWIDTH/8-1:0] wb_sel_i,
    input  logic                wb_lock_i,
    input  logic                wb_tga_i,
    input  logic                wb_tgc_i,
    output logic [DWIDTH-1:0]   wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                wb_rty_o,
    output logic                wb_stall_o
);

    localparam int unsigned SW    = DWIDTH / 8;
    localparam int unsigned DEPTH = 1 << MEM_AW;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic              accept;
    logic              hit;
    logic [MEM_AW-1:0] idx;
    logic [DWIDTH-1:0] rd_word;

    logic [LATENCY-1:0] pv;
    logic [LATENCY-1:0] pe;
    logic [DWIDTH-1:0]  pd [LATENCY];

    logic unused;
    assign unused = ^{wb_lock_i, wb_tga_i, wb_tgc_i, wb_adr_i[1:0]};

    assign accept  = wb_cyc_i & wb_stb_i & ~wb_stall_o & ~wb_rst_i;
    assign hit     = wb_adr_i[AWIDTH-1:MEM_AW+2]
                     == BASE_ADDR[AWIDTH-1:MEM_AW+2];
    assign idx     = wb_adr_i[MEM_AW+1:2];
    assign rd_word = mem[idx];

    // Byte-masked write of an accepted hit; contents survive reset.
    always_ff @(posedge wb_clk_i) begin
        for (int b = 0; b < SW; b++) begin
            if (accept && hit && wb_we_i && wb_sel_i[b]) begin
                mem[idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
        end
    end

    // Response shift pipeline; dropping cyc kills every in-flight beat.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pv <= '0;
            pe <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= accept;
            pe[0] <= ~hit;
            pd[0] <= (hit && !wb_we_i) ? rd_word : '0;
            for (int i = 1; i < LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pd[i] <= pd[i-1];
            end
            if (!wb_cyc_i) begin
                pv <= '0;
            end
        end
    end

    assign wb_ack_o = pv[LATENCY-1] & ~pe[LATENCY-1];
    assign wb_err_o = pv[LATENCY-1] & pe[LATENCY-1];
    assign wb_dat_o = wb_ack_o ? pd[LATENCY-1] : '0;
    assign wb_rty_o = 1'b0;

    generate
        if (STALL_EVERY == 0) begin : g_no_stall
            assign wb_stall_o = 1'b0;
        end else begin : g_stall
            logic [31:0] cnt;
            logic        stall_q;

            // Count accepts; after every Nth one refuse the next cycle.
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    cnt     <= '0;
                    stall_q <= 1'b0;
                end else begin
                    stall_q <= 1'b0;
                    if (accept) begin
                        if (cnt == STALL_EVERY - 1) begin
                            cnt     <= '0;
                            stall_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                end
            end

            assign wb_stall_o = stall_q;
        end
    endgenerate

endmodule
